serial_add_sub: RTL
===================

// Module: serial_add_sub
//
// PURPOSE
//   Bit-serial two's-complement adder/subtractor for the add_sub datapath.
//   Loads two WIDTH-bit operands, then on each cycle feeds one bit pair plus
//   the registered carry into a single full-adder cell (fa).
//   Assembles the result LSB-first over WIDTH cycles.
//   Trades latency for area against the parallel ripple adder. Downstream
//   consumers read result/flags on the done pulse.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
//
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      request; sampled only in IDLE or DONE
//   sub        in   1      0 = op_a + op_b, 1 = op_a - op_b; sampled with start
//   op_a       in   WIDTH  operand A; sampled with start
//   op_b       in   WIDTH  operand B; sampled with start
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle pulse: result/flags valid
//   result     out  WIDTH  sum/difference; held stable until next accepted start
//   carry_out  out  1      carry from MSB; for sub, 1 = no borrow (op_a >= op_b unsigned)
//   overflow   out  1      signed overflow = carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
//   - Reset (async assert, any state): state=IDLE, busy=0, done=0, result=0,
//     carry_out=0, overflow=0, shift regs, carry flop and bit counter = 0.
//   - FSM: IDLE -(start)-> RUN; RUN -(bit counter == WIDTH-1)-> DONE;
//     DONE -(start)-> RUN, else -> IDLE. DONE lasts exactly one cycle.
//   - Accept, on the edge where start=1 in IDLE/DONE:
//     - A_sr <= op_a.
//     - B_sr <= sub ? ~op_b : op_b.
//     - carry flop <= sub.
//     - counter <= 0.
//     - result keeps its old value until overwritten by shifting.
//   - RUN, each cycle (fa inputs: a=A_sr[0], b=B_sr[0], c=carry flop):
//     - A_sr, B_sr shift right by 1.
//     - Result shift reg shifts right; fa.sum enters at bit WIDTH-1.
//     - carry flop <= fa.carry.
//     - counter increments.
//   - On the last RUN cycle (counter == WIDTH-1):
//     - carry_out <= fa.carry.
//     - overflow <= fa.carry XOR carry flop; the carry flop holds the carry
//       into the MSB.
//   - Latency: start accepted at edge 0; RUN on edges 1..WIDTH; done=1 in the
//     cycle after edge WIDTH, i.e. WIDTH+1 cycles start-to-done.
//   - start during RUN is ignored: no restart, and operands are not resampled.
//   - start in DONE: accepted, so back-to-back ops give no idle gap.
//   - done is still 1 in that DONE cycle; result reflects the finished op.
//   - busy=1 exactly in RUN; busy and done are never high together.
//   - result/carry_out/overflow are only guaranteed while done=1 or in IDLE;
//     during RUN result contains partially shifted data.
//   - Wrap-around: arithmetic is modulo 2^WIDTH; the extra bit is reported
//     only via carry_out.
//   - Reset mid-RUN aborts immediately: no done pulse, all outputs zero.
//     The first start after deassertion behaves as from power-up.
//
// TESTING  (WIDTH=8)
//   1. add 0x3C+0x05 -> done at start+9 cycles; result=0x41, carry_out=0, overflow=0
//   2. add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> 0x80, ovf=1
//   3. sub 0x05-0x07 -> result=0xFE, carry_out=0; sub 0x80-0x01 -> 0x7F, carry_out=1, ovf=1
//   4. start pulsed again at RUN cycle 4 with other operands -> ignored; first result intact
//   5. start held high in DONE of 0x10+0x20 (=0x30), next op 0x01-0x01
//      -> next done 9 cycles later, result=0x00, carry_out=1
//   6. rst asserted at RUN cycle 3 -> busy=0/result=0 immediately, no done;
//      next add 0x02+0x03 -> 0x05

Source files
------------

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's-complement adder/subtractor.
// Operands are loaded into shift registers. One full-adder cell then handles
// one bit pair per cycle, LSB first. The registered carry links one bit to
// the next. The finished result and flags are presented with a one-cycle
// done pulse.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_out_reg;
  logic             overflow_reg;

  logic accept;
  logic last_bit;
  logic fa_sum;
  logic fa_carry;

  // A new operation is only taken when no operation is in flight.
  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit = (cnt_reg == LAST);

  // Single full-adder cell: one bit of A and B plus the carry from the previous bit.
  assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry_reg;
  assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_reg) | (b_sr[0] & carry_reg);

  // Next-state logic: DONE lasts one cycle and can chain straight into RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand shift registers, carry flop and bit counter.
  // Subtraction is done as A + ~B + 1: B is inverted on load and the carry is seeded with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_sr      <= op_a;
      b_sr      <= sub ? ~op_b : op_b;
      carry_reg <= sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
      carry_reg <= fa_carry;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  // Result assembly: each sum bit enters at the top, so after WIDTH shifts the LSB sits at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     res_sr <= '0;
    else if (state_reg == RUN)   res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
  end

  // Flags are captured on the MSB cycle. At that point the carry flop holds the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if ((state_reg == RUN) && last_bit) begin
      carry_out_reg <= fa_carry;
      overflow_reg  <= fa_carry ^ carry_reg;
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign result    = res_sr;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;

endmodule
